// File: rtl/div_pkg.sv
// Shared types and default widths for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DW_DEFAULT = 8;
    localparam int DIV_VW_DEFAULT = 4;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference or restore the shifted value.
module div_step
    import div_pkg::*;
#(
    parameter int VW = DIV_VW_DEFAULT
) (
    input  logic [VW:0]   i_prem,
    input  logic          i_dvd_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_prem,
    output logic          o_qbit
);

    logic [VW:0] w_shift;
    logic [VW:0] w_diff;
    logic        w_borrow;

    assign w_shift             = {i_prem[VW-1:0], i_dvd_bit};
    assign {w_borrow, w_diff}  = {1'b0, w_shift} - {2'b00, i_divisor};

    // A set top bit in the incoming remainder means the shifted value already
    // exceeds any VW-bit divisor, so the subtraction always succeeds.
    assign o_qbit = i_prem[VW] | ~w_borrow;
    assign o_prem = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional divide-by-zero short-cut and flag under `DIV_ZERO_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one restoring step per cycle, DW steps total
//   DONE  | results registered, done pulse; start here chains a new operation
module restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT,
    parameter int VW = DIV_VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    div_state_t    r_state;
    div_state_t    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_divisor;
    logic [VW:0]   r_prem;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic [VW:0]   w_prem_next;
    logic          w_qbit;
    logic          w_accept;
    logic          w_zero;
    logic          w_last;

    div_step #(
        .VW (VW)
    ) u_step (
        .i_prem    (r_prem),
        .i_dvd_bit (r_dvd[DW-1]),
        .i_divisor (r_divisor),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

`ifdef DIV_ZERO_CHECK_EN
    assign w_zero = (r_divisor == '0);
`else
    assign w_zero = 1'b0;
`endif

    // A zero divisor ends RUN on its first cycle instead of stepping.
    assign w_last = (r_state == RUN) && ((r_cnt == CW'(1)) || w_zero);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: w_state_next = start ? RUN : IDLE;
            RUN:        if (w_last) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The dividend register doubles as the quotient accumulator: each step
    // shifts out a dividend bit at the top and shifts a quotient bit in below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_dvd     <= dividend;
            r_divisor <= divisor;
            r_prem    <= '0;
            r_cnt     <= CW'(DW);
        end else if (r_state == RUN) begin
            r_dvd  <= {r_dvd[DW-2:0], w_qbit};
            r_prem <= w_prem_next;
            r_cnt  <= r_cnt - CW'(1);
            if (w_last) begin
                if (w_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                end else begin
                    r_quotient  <= {r_dvd[DW-2:0], w_qbit};
                    r_remainder <= w_prem_next[VW-1:0];
                end
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic r_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz <= 1'b0;
        end else if (w_last) begin
            r_dz <= w_zero;
        end
    end

    assign div_by_zero = r_dz;
`else
    assign div_by_zero = 1'b0;
`endif

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (DW=8, VW=4).
module tb_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    restoring_divider #(
        .DW (8),
        .VW (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start; returns at the falling edge after the sampling edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts rising edges, the start-sampling edge being number 1.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic op(input string tag, input logic [7:0] a, input logic [3:0] b,
                      input logic [7:0] eq, input logic [3:0] er, input logic edz,
                      input int elat);
        int lat;
        launch(a, b);
        chk({tag, "_busy"}, busy, 1);
        wait_done(1, lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, edz);
        @(negedge clk);
        chk({tag, "_done_w"}, done, 0);
        chk({tag, "_q_hold"}, quotient, eq);
    endtask

    initial begin
        int lat;
        int n_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;

        op("d44_4", 8'd44, 4'd4, 8'd11, 4'd0, 1'b0, 9);
        op("d91_7", 8'd91, 4'd7, 8'd13, 4'd0, 1'b0, 9);
        op("d225_15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 9);
        op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9);
        op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
        op("d0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 9);
`ifdef DIV_ZERO_CHECK_EN
        op("d13_0", 8'd13, 4'd0, 8'd255, 4'd0, 1'b1, 2);
`else
        op("d13_0", 8'd13, 4'd0, 8'd255, 4'd13, 1'b0, 9);
`endif
        op("d100_11", 8'd100, 4'd11, 8'd9, 4'd1, 1'b0, 9);

        // reset in the middle of an operation
        launch(8'd200, 4'd7);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_busy_pre", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        dividend = 8'd9;
        divisor  = 4'd3;
        start    = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_busy", busy, 1);
        wait_done(1, lat);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_q", quotient, 3);
        chk("post_rst_r", remainder, 0);
        @(negedge clk);

        // a start pulse during RUN must not disturb the running operation
        launch(8'd63, 4'd9);
        dividend = 8'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat);
        chk("ign_lat", lat, 9);
        chk("ign_q", quotient, 7);
        chk("ign_r", remainder, 0);
        n_done = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("ign_extra_done", n_done, 0);
        chk("ign_q_hold", quotient, 7);

        // back-to-back: start held high through DONE
        @(negedge clk);
        dividend = 8'd91;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(1, lat);
        chk("b2b1_lat", lat, 9);
        chk("b2b1_q", quotient, 13);
        chk("b2b1_r", remainder, 0);
        dividend = 8'd225;
        divisor  = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_w", done, 0);
        chk("b2b_busy", busy, 1);
        wait_done(1, lat);
        chk("b2b2_lat", lat, 9);
        chk("b2b2_q", quotient, 15);
        chk("b2b2_r", remainder, 0);
        @(negedge clk);
        chk("b2b2_done_w", done, 0);
        chk("b2b2_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
